// File: rtl/stk_bank_arb_pkg.sv
// Shared types and sizes for the stack bank arbiter: opcodes, stack pointers,
// bank command record and engine/bank counts.
package stk_bank_arb_pkg;

  localparam int ENGS_N     = 4;
  localparam int BANKS_N    = 4;
  localparam int ENGID_W    = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
  localparam int BNK_ID_W   = $clog2(BANKS_N);
  localparam int LINE_ID_W  = 8;
  localparam int OPCODE_W   = 2;
  localparam int CMD_DATA_W = 32;

  typedef logic [ENGID_W-1:0]   engid_t;
  typedef logic [BNK_ID_W-1:0]  bnk_id_t;
  typedef logic [LINE_ID_W-1:0] line_id_t;

  typedef enum logic [OPCODE_W-1:0] {
    OPCODE_NOP  = 2'd0,
    OPCODE_PUSH = 2'd1,
    OPCODE_POP  = 2'd2,
    OPCODE_INV  = 2'd3
  } opcode_t;

  typedef struct packed {
    bnk_id_t  bnk_id;
    line_id_t line_id;
  } ptr_t;

  localparam int PTR_W = $bits(ptr_t);

  typedef struct packed {
    logic                  wen;
    line_id_t              line_id;
    logic [CMD_DATA_W-1:0] dat;
  } bnk_cmd_t;

endpackage

// File: rtl/stk_rr_arb.sv
// Single-bank round-robin arbiter: one-hot grant to the first requester at or
// after the priority pointer; the pointer moves past each winner.
module stk_rr_arb #(
  parameter int ENGS_N = stk_bank_arb_pkg::ENGS_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ENGS_N-1:0] req_i,
  output logic [ENGS_N-1:0] gnt_o
);

  localparam int PRIO_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

  logic [PRIO_W-1:0] prio_q, prio_d;
  logic [PRIO_W-1:0] idx;
  logic              found;
  int                sum;

  always_comb begin
    gnt_o  = '0;
    prio_d = prio_q;
    found  = 1'b0;
    idx    = '0;
    sum    = 0;
    for (int i = 0; i < ENGS_N; i++) begin
      sum = int'(prio_q) + i;
      if (sum >= ENGS_N) sum = sum - ENGS_N;
      idx = PRIO_W'(sum);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        prio_d     = (sum == ENGS_N - 1) ? '0 : PRIO_W'(sum + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= '0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/stk_bank_arb.sv
// Shares the stack SRAM banks between the stack engines: per-bank round-robin
// grant, flopped bank commands, and fixed 3-cycle POP data return.
module stk_bank_arb #(
  parameter int ENGS_N = stk_bank_arb_pkg::ENGS_N,
  parameter int DATA_W = 32
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic [ENGS_N-1:0]                                           i_req_vld,
  input  logic [ENGS_N-1:0][stk_bank_arb_pkg::OPCODE_W-1:0]           i_req_opcode,
  input  logic [ENGS_N-1:0][stk_bank_arb_pkg::PTR_W-1:0]              i_req_ptr,
  input  logic [ENGS_N-1:0][DATA_W-1:0]                               i_req_dat,
  output logic [ENGS_N-1:0]                                           o_req_rdy,
  output logic [stk_bank_arb_pkg::BANKS_N-1:0]                        o_bnk_en,
  output logic [stk_bank_arb_pkg::BANKS_N-1:0]                        o_bnk_wen,
  output logic [stk_bank_arb_pkg::BANKS_N-1:0][stk_bank_arb_pkg::LINE_ID_W-1:0] o_bnk_addr,
  output logic [stk_bank_arb_pkg::BANKS_N-1:0][DATA_W-1:0]            o_bnk_wdat,
  input  logic [stk_bank_arb_pkg::BANKS_N-1:0][DATA_W-1:0]            i_bnk_rdat,
  output logic [ENGS_N-1:0]                                           o_rsp_vld,
  output logic [ENGS_N-1:0][DATA_W-1:0]                               o_rsp_dat,
  output logic [ENGS_N-1:0]                                           o_err_inv
);

  import stk_bank_arb_pkg::*;

  ptr_t [ENGS_N-1:0]                req_ptr;
  logic [ENGS_N-1:0]                req_push, req_pop, req_inv;
  logic [BANKS_N-1:0][ENGS_N-1:0]   bnk_req, bnk_gnt;
  logic [ENGS_N-1:0]                eng_gnt;

  logic [BANKS_N-1:0]                bnk_en_q, bnk_en_d;
  logic [BANKS_N-1:0]                bnk_wen_q, bnk_wen_d;
  logic [BANKS_N-1:0][LINE_ID_W-1:0] bnk_addr_q, bnk_addr_d;
  logic [BANKS_N-1:0][DATA_W-1:0]    bnk_wdat_q, bnk_wdat_d;
  logic [BANKS_N-1:0][ENGS_N-1:0]    tag_p1_q, tag_p1_d, tag_p2_q;
  logic [ENGS_N-1:0]                 rsp_vld_q, rsp_vld_d;
  logic [ENGS_N-1:0][DATA_W-1:0]     rsp_dat_q, rsp_dat_d;
  logic [ENGS_N-1:0]                 err_inv_q;

  assign req_ptr = i_req_ptr;

  // NOP with vld set is simply not a request.
  always_comb begin
    req_push = '0;
    req_pop  = '0;
    req_inv  = '0;
    bnk_req  = '0;
    for (int e = 0; e < ENGS_N; e++) begin
      if (i_req_vld[e]) begin
        case (opcode_t'(i_req_opcode[e]))
          OPCODE_PUSH: req_push[e] = 1'b1;
          OPCODE_POP:  req_pop[e]  = 1'b1;
          OPCODE_INV:  req_inv[e]  = 1'b1;
          default: ;
        endcase
      end
      bnk_req[req_ptr[e].bnk_id][e] = req_push[e] | req_pop[e];
    end
  end

  for (genvar b = 0; b < BANKS_N; b++) begin : g_arb
    stk_rr_arb #(.ENGS_N(ENGS_N)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (bnk_req[b]),
      .gnt_o (bnk_gnt[b])
    );
  end

  always_comb begin
    eng_gnt    = '0;
    bnk_en_d   = '0;
    bnk_wen_d  = '0;
    bnk_addr_d = '0;
    bnk_wdat_d = '0;
    tag_p1_d   = '0;
    for (int b = 0; b < BANKS_N; b++) begin
      for (int e = 0; e < ENGS_N; e++) begin
        if (bnk_gnt[b][e]) begin
          eng_gnt[e]    = 1'b1;
          bnk_en_d[b]   = 1'b1;
          bnk_wen_d[b]  = req_push[e];
          bnk_addr_d[b] = req_ptr[e].line_id;
          bnk_wdat_d[b] = req_push[e] ? i_req_dat[e] : '0;
          tag_p1_d[b][e] = req_pop[e];
        end
      end
    end
  end

  assign o_req_rdy = rst_n ? (eng_gnt | req_inv) : '0;

  // Read data arrives with the stage-2 tag; route it to the issuing engine.
  always_comb begin
    rsp_vld_d = '0;
    rsp_dat_d = rsp_dat_q;
    for (int b = 0; b < BANKS_N; b++) begin
      for (int e = 0; e < ENGS_N; e++) begin
        if (tag_p2_q[b][e]) begin
          rsp_vld_d[e] = 1'b1;
          rsp_dat_d[e] = i_bnk_rdat[b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bnk_en_q   <= '0;
      bnk_wen_q  <= '0;
      bnk_addr_q <= '0;
      bnk_wdat_q <= '0;
      tag_p1_q   <= '0;
      tag_p2_q   <= '0;
      rsp_vld_q  <= '0;
      rsp_dat_q  <= '0;
      err_inv_q  <= '0;
    end else begin
      bnk_en_q   <= bnk_en_d;
      bnk_wen_q  <= bnk_wen_d;
      bnk_addr_q <= bnk_addr_d;
      bnk_wdat_q <= bnk_wdat_d;
      tag_p1_q   <= tag_p1_d;
      tag_p2_q   <= tag_p1_q;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      err_inv_q  <= req_inv;
    end
  end

  assign o_bnk_en   = bnk_en_q;
  assign o_bnk_wen  = bnk_wen_q;
  assign o_bnk_addr = bnk_addr_q;
  assign o_bnk_wdat = bnk_wdat_q;
  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_dat  = rsp_dat_q;
  assign o_err_inv  = err_inv_q;

endmodule

// File: tb/tb_stk_bank_arb.sv
// Bench for stk_bank_arb: table-driven grant vectors, hand sequences for
// contention, wrap and reset, and a scoreboard for bank strobes and responses.
module tb_stk_bank_arb;

  import stk_bank_arb_pkg::*;

  localparam int N  = ENGS_N;
  localparam int B  = BANKS_N;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]                 req_vld;
  logic [N-1:0][OPCODE_W-1:0]   req_op;
  logic [N-1:0][PTR_W-1:0]      req_ptr;
  logic [N-1:0][DW-1:0]         req_dat;
  logic [N-1:0]                 o_req_rdy;
  logic [B-1:0]                 o_bnk_en, o_bnk_wen;
  logic [B-1:0][LINE_ID_W-1:0]  o_bnk_addr;
  logic [B-1:0][DW-1:0]         o_bnk_wdat;
  logic [B-1:0][DW-1:0]         bnk_rdat;
  logic [N-1:0]                 o_rsp_vld;
  logic [N-1:0][DW-1:0]         o_rsp_dat;
  logic [N-1:0]                 o_err_inv;

  always #5 clk = ~clk;

  stk_bank_arb #(.ENGS_N(N), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_vld    (req_vld),
    .i_req_opcode (req_op),
    .i_req_ptr    (req_ptr),
    .i_req_dat    (req_dat),
    .o_req_rdy    (o_req_rdy),
    .o_bnk_en     (o_bnk_en),
    .o_bnk_wen    (o_bnk_wen),
    .o_bnk_addr   (o_bnk_addr),
    .o_bnk_wdat   (o_bnk_wdat),
    .i_bnk_rdat   (bnk_rdat),
    .o_rsp_vld    (o_rsp_vld),
    .o_rsp_dat    (o_rsp_dat),
    .o_err_inv    (o_err_inv)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int b, input int l);
    if (b == 2 && l == 5) return 32'hDEAD_BEEF;
    return 32'h5A5A_0000 ^ {16'(b), 16'(l)};
  endfunction

  function automatic logic [PTR_W-1:0] mkptr(input int b, input int l);
    return {BNK_ID_W'(b), LINE_ID_W'(l)};
  endfunction

  // SRAM bank model: one-cycle read latency, unwritten lines hold init_val.
  bit [DW-1:0] mem    [B][256];
  bit          mem_wr [B][256];
  always @(posedge clk) begin
    for (int b = 0; b < B; b++) begin
      if (o_bnk_en[b]) begin
        if (o_bnk_wen[b]) begin
          mem[b][o_bnk_addr[b]]    <= o_bnk_wdat[b];
          mem_wr[b][o_bnk_addr[b]] <= 1'b1;
        end else begin
          bnk_rdat[b] <= mem_wr[b][o_bnk_addr[b]] ? mem[b][o_bnk_addr[b]]
                                                  : init_val(b, int'(o_bnk_addr[b]));
        end
      end
    end
  end

  // Scoreboard: expectations pushed at acceptance, popped when due.
  typedef struct { int due; int bnk; logic wen; logic [LINE_ID_W-1:0] addr; logic [DW-1:0] wdat; } bcmd_t;
  typedef struct { int due; int eng; logic [DW-1:0] dat; } rsp_t;
  typedef struct { int due; int eng; } inv_t;

  bcmd_t bq[$];
  rsp_t  rq[$];
  inv_t  iq[$];
  bit [DW-1:0] ref_mem [B][256];
  bit          ref_wr  [B][256];
  bit          mon_en = 1'b0;
  int          cyc = 0;

  bcmd_t c;
  rsp_t  r;
  inv_t  iv;
  ptr_t  p;
  opcode_t op;
  logic [B-1:0]                ex_en, ex_wen;
  logic [B-1:0][LINE_ID_W-1:0] ex_addr;
  logic [B-1:0][DW-1:0]        ex_wdat;
  logic [N-1:0]                ex_rvld, ex_inv;
  logic [N-1:0][DW-1:0]        ex_rdat;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      ex_en = '0; ex_wen = '0; ex_addr = '0; ex_wdat = '0;
      ex_rvld = '0; ex_rdat = '0; ex_inv = '0;
      while (bq.size() > 0 && bq[0].due <= cyc) begin
        c = bq.pop_front();
        ex_en[c.bnk] = 1'b1; ex_wen[c.bnk] = c.wen;
        ex_addr[c.bnk] = c.addr; ex_wdat[c.bnk] = c.wdat;
      end
      while (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        ex_rvld[r.eng] = 1'b1; ex_rdat[r.eng] = r.dat;
      end
      while (iq.size() > 0 && iq[0].due <= cyc) begin
        iv = iq.pop_front();
        ex_inv[iv.eng] = 1'b1;
      end
      chk("bnk_en", 64'(o_bnk_en), 64'(ex_en));
      for (int b = 0; b < B; b++)
        if (ex_en[b])
          chk($sformatf("bnk_cmd[%0d]", b),
              64'({o_bnk_wen[b], o_bnk_addr[b], (o_bnk_wen[b] ? o_bnk_wdat[b] : 32'h0)}),
              64'({ex_wen[b], ex_addr[b], ex_wdat[b]}));
      chk("rsp_vld", 64'(o_rsp_vld), 64'(ex_rvld));
      for (int e = 0; e < N; e++)
        if (ex_rvld[e]) chk($sformatf("rsp_dat[%0d]", e), 64'(o_rsp_dat[e]), 64'(ex_rdat[e]));
      chk("err_inv", 64'(o_err_inv), 64'(ex_inv));
      if (!rst_n) begin
        bq.delete(); rq.delete(); iq.delete();
      end else begin
        for (int e = 0; e < N; e++) begin
          if (req_vld[e] && o_req_rdy[e]) begin
            op = opcode_t'(req_op[e]);
            p  = ptr_t'(req_ptr[e]);
            if (op == OPCODE_INV) begin
              iq.push_back('{cyc + 1, e});
            end else begin
              c = '{cyc + 1, int'(p.bnk_id), (op == OPCODE_PUSH), p.line_id,
                    (op == OPCODE_PUSH) ? req_dat[e] : 32'h0};
              bq.push_back(c);
              if (op == OPCODE_PUSH) begin
                ref_mem[p.bnk_id][p.line_id] = req_dat[e];
                ref_wr[p.bnk_id][p.line_id]  = 1'b1;
              end else begin
                rq.push_back('{cyc + 3, e, ref_wr[p.bnk_id][p.line_id] ?
                               ref_mem[p.bnk_id][p.line_id] :
                               init_val(int'(p.bnk_id), int'(p.line_id))});
              end
            end
          end
        end
      end
    end
  end

  typedef struct {
    string                      name;
    logic [N-1:0]               vld;
    logic [N-1:0][OPCODE_W-1:0] op;
    logic [N-1:0][PTR_W-1:0]    ptr;
    logic [N-1:0][DW-1:0]       dat;
    logic [N-1:0]               exp_rdy;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req_vld = '0; req_op = '0; req_ptr = '0; req_dat = '0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; idle();
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) begin
      vecs[i].vld = '0; vecs[i].op = '0; vecs[i].ptr = '0; vecs[i].dat = '0;
    end
    vecs[0].name = "single_pop";  vecs[0].vld = 4'b0001; vecs[0].op[0] = OPCODE_POP;
    vecs[0].ptr[0] = mkptr(2, 5); vecs[0].exp_rdy = 4'b0001;
    vecs[1].name = "par_push";    vecs[1].vld = 4'b1111; vecs[1].exp_rdy = 4'b1111;
    for (int e = 0; e < N; e++) begin
      vecs[1].op[e] = OPCODE_PUSH; vecs[1].ptr[e] = mkptr(e, 10 + e);
      vecs[1].dat[e] = 32'hA000_0000 + 32'(e);
    end
    vecs[2].name = "inv_nop";     vecs[2].vld = 4'b0110; vecs[2].op[1] = OPCODE_INV;
    vecs[2].op[2] = OPCODE_NOP;   vecs[2].exp_rdy = 4'b0010;
    vecs[3].name = "b0_contend";  vecs[3].vld = 4'b0011;
    vecs[3].op[0] = OPCODE_POP;   vecs[3].ptr[0] = mkptr(0, 10);
    vecs[3].op[1] = OPCODE_POP;   vecs[3].ptr[1] = mkptr(0, 10); vecs[3].exp_rdy = 4'b0010;
    vecs[4].name = "b0_follow";   vecs[4].vld = 4'b0001;
    vecs[4].op[0] = OPCODE_POP;   vecs[4].ptr[0] = mkptr(0, 10); vecs[4].exp_rdy = 4'b0001;
    vecs[5].name = "two_banks";   vecs[5].vld = 4'b1100;
    vecs[5].op[2] = OPCODE_POP;   vecs[5].ptr[2] = mkptr(1, 11);
    vecs[5].op[3] = OPCODE_POP;   vecs[5].ptr[3] = mkptr(3, 13); vecs[5].exp_rdy = 4'b1100;
    vecs[6].name = "b2_wrap";     vecs[6].vld = 4'b0101;
    vecs[6].op[0] = OPCODE_POP;   vecs[6].ptr[0] = mkptr(2, 12);
    vecs[6].op[2] = OPCODE_POP;   vecs[6].ptr[2] = mkptr(2, 12); vecs[6].exp_rdy = 4'b0001;

    // reset state, with requests held to show rdy is masked
    rst_n = 1'b0;
    req_vld = '1; req_dat = '0;
    for (int e = 0; e < N; e++) begin req_op[e] = OPCODE_POP; req_ptr[e] = mkptr(e, e); end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(o_req_rdy), 64'h0);
    chk("rst_bnk", 64'({o_bnk_en, o_bnk_wen, |o_bnk_addr, |o_bnk_wdat}), 64'h0);
    chk("rst_rsp", 64'({o_rsp_vld, |o_rsp_dat, o_err_inv}), 64'h0);
    mon_en = 1'b1;
    step();
    idle(); rst_n = 1'b1;

    foreach (vecs[i]) begin
      step();
      req_vld = vecs[i].vld; req_op = vecs[i].op; req_ptr = vecs[i].ptr; req_dat = vecs[i].dat;
      @(negedge clk);
      chk({"rdy_", vecs[i].name}, 64'(o_req_rdy), 64'(vecs[i].exp_rdy));
    end
    step(); idle();
    repeat (5) step();

    // contention: all engines hold POP to bank 1 from reset
    do_reset();
    step();
    req_vld = '1;
    for (int e = 0; e < N; e++) begin req_op[e] = OPCODE_POP; req_ptr[e] = mkptr(1, 20 + e); end
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      chk($sformatf("contend_%0d", k), 64'(o_req_rdy), 64'(1) << (k % N));
      step();
    end
    idle();
    repeat (5) step();

    // wrap: bank 3 pointer left at N-1, then engines N-1 and 0 contend
    do_reset();
    step();
    req_vld = '0; req_vld[N-2] = 1'b1;
    req_op[N-2] = OPCODE_PUSH; req_ptr[N-2] = mkptr(3, 30); req_dat[N-2] = 32'hC0FF_EE00;
    @(negedge clk);
    chk("wrap_push", 64'(o_req_rdy), 64'(1) << (N - 2));
    step();
    req_vld = '0; req_vld[N-1] = 1'b1; req_vld[0] = 1'b1;
    req_op[N-1] = OPCODE_POP; req_ptr[N-1] = mkptr(3, 30);
    req_op[0] = OPCODE_POP;   req_ptr[0]   = mkptr(3, 30);
    @(negedge clk);
    chk("wrap_first", 64'(o_req_rdy), 64'(1) << (N - 1));
    step();
    req_vld[N-1] = 1'b0;
    @(negedge clk);
    chk("wrap_second", 64'(o_req_rdy), 64'h1);
    step(); idle();
    repeat (5) step();

    // reset one cycle after a POP accept: the response must never appear
    step();
    req_vld = 4'b0001; req_op[0] = OPCODE_POP; req_ptr[0] = mkptr(2, 5);
    @(negedge clk);
    chk("mid_accept", 64'(o_req_rdy), 64'h1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy", 64'(o_req_rdy), 64'h0);
    step();
    rst_n = 1'b1; idle();
    @(negedge clk);
    chk("mid_bnk_zero", 64'({o_bnk_en, o_bnk_wen, |o_bnk_addr, |o_bnk_wdat}), 64'h0);
    chk("mid_rsp_zero", 64'({o_rsp_vld, |o_rsp_dat, o_err_inv}), 64'h0);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
